// File: rtl/mem_responder_if.sv
// Memory request/response bundle between the RV32 core (master) and mem_responder (slave).
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  func3;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata, func3,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, we, addr, wdata, func3,
    output rdata, ack, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Unified I/D memory responder: one request at a time, WAIT_STATES wait cycles, one-cycle ack.
// Define MEM_MISALIGN_CHECK_EN to reject misaligned h/w accesses instead of aligning them.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS4 = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [AW+1:0]     r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_func3;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_ack, w_busy, w_enter_resp;
  logic              w_acc_we;
  logic [AW+1:0]     w_acc_addr;
  logic [31:0]       w_acc_wdata;
  logic [2:0]        w_acc_f3;
  logic [AW-1:0]     w_idx;
  logic [1:0]        w_off;
  logic [31:0]       w_word, w_shifted, w_load, w_rdata_nx, w_wlanes;
  logic [3:0]        w_wmask;
  logic              w_reserved, w_misalign, w_err, w_mem_we;
  logic              w_unused_addr;

  assign w_unused_addr = |bus.addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.req) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr[AW+1:0];
        r_wdata <= bus.wdata;
        r_func3 <= bus.func3;
        r_cnt   <= WS4;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rdata <= w_rdata_nx;
        r_err   <= w_err;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_ack  = 1'b0;
    w_busy = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.req) w_next = (WS4 == 4'd0) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP: begin
        w_ack  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states the access runs on the capture edge, so it must use the live inputs.
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_acc_we     = (r_state == S_IDLE) ? bus.we              : r_we;
  assign w_acc_addr   = (r_state == S_IDLE) ? bus.addr[AW+1:0]    : r_addr;
  assign w_acc_wdata  = (r_state == S_IDLE) ? bus.wdata           : r_wdata;
  assign w_acc_f3     = (r_state == S_IDLE) ? bus.func3           : r_func3;

  assign w_idx  = w_acc_addr[AW+1:2];
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_reserved = (w_acc_f3 == 3'b011) || (w_acc_f3 == 3'b110) || (w_acc_f3 == 3'b111) ||
                 (w_acc_we && w_acc_f3[2]);
`ifdef MEM_MISALIGN_CHECK_EN
    w_misalign = ((w_acc_f3[1:0] == 2'b01) && w_acc_addr[0]) ||
                 ((w_acc_f3[1:0] == 2'b10) && (w_acc_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_err = w_reserved || w_misalign;
  end

  // Size-aligned lane offset; in the non-checking build this is what forces misaligned bits to zero.
  always_comb begin
    w_off    = 2'b00;
    w_wmask  = 4'b1111;
    w_wlanes = w_acc_wdata;
    case (w_acc_f3[1:0])
      2'b00: begin
        w_off    = w_acc_addr[1:0];
        w_wmask  = 4'b0001 << w_off;
        w_wlanes = {4{w_acc_wdata[7:0]}};
      end
      2'b01: begin
        w_off    = {w_acc_addr[1], 1'b0};
        w_wmask  = w_acc_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_shifted = w_word >> {w_off, 3'b000};
    w_load    = '0;
    case (w_acc_f3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      3'b010:  w_load = w_word;
      default: w_load = '0;
    endcase
    w_rdata_nx = (w_acc_we || w_err) ? '0 : w_load;
  end

  assign w_mem_we = w_enter_resp && w_acc_we && !w_err && !reset;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  assign bus.ack   = w_ack;
  assign bus.busy  = w_busy;
  assign bus.rdata = r_rdata;
  assign bus.err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_STATES=1 instance for data/latency, WAIT_STATES=3 for reset abort.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst1, rst3;
  always #5 clk = ~clk;

  mem_responder_if b1();
  mem_responder_if b3();

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (.clk(clk), .reset(rst1), .bus(b1.slave));
  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(rst3), .bus(b3.slave));

  logic [1:0]  req_v, we_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [2:0]  f3_v    [2];

  assign b1.req = req_v[0];  assign b1.we = we_v[0];  assign b1.addr = addr_v[0];
  assign b1.wdata = wdata_v[0];  assign b1.func3 = f3_v[0];
  assign b3.req = req_v[1];  assign b3.we = we_v[1];  assign b3.addr = addr_v[1];
  assign b3.wdata = wdata_v[1];  assign b3.func3 = f3_v[1];

  logic [1:0]  ack_w, busy_w, err_w;
  logic [31:0] rdata_w [2];
  assign ack_w  = {b3.ack, b1.ack};
  assign busy_w = {b3.busy, b1.busy};
  assign err_w  = {b3.err, b1.err};
  assign rdata_w[0] = b1.rdata;
  assign rdata_w[1] = b3.rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f, output logic [31:0] rd, output logic e, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_w[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_v[k] = 1'b1; we_v[k] = w; addr_v[k] = a; wdata_v[k] = wd; f3_v[k] = f;
    @(posedge clk); #1;
    lat = 1;
    while (!ack_w[k] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    req_v[k] = 1'b0;
    check("ack_seen", {31'd0, ack_w[k]}, 32'd1);
    rd = rdata_w[k];
    e  = err_w[k];
  endtask

  task automatic txn(input string tag, input int k, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] f,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic e;
    int lat;
    access(k, w, a, wd, f, rd, e, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    int acks;
    rst1 = 1'b1; rst3 = 1'b1;
    req_v = '0; we_v = '0;
    for (int i = 0; i < 2; i++) begin
      addr_v[i] = '0; wdata_v[i] = '0; f3_v[i] = 3'b010;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   {31'd0, ack_w[0]},  32'd0);
    check("rst_busy",  {31'd0, busy_w[0]}, 32'd0);
    check("rst_err",   {31'd0, err_w[0]},  32'd0);
    check("rst_rdata", rdata_w[0],         32'd0);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    txn("sw10",   0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 2);
    txn("lw10",   0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 2);
    repeat (3) @(negedge clk);
    check("rdata_hold", rdata_w[0], 32'hDEADBEEF);

    txn("sb13",   0, 1'b1, 32'h13, 32'h80,       3'b000, 32'h0,        1'b0, 2);
    txn("lb13",   0, 1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, 2);
    txn("lbu13",  0, 1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0, 2);
    txn("lw10b",  0, 1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0, 2);

    txn("sh12",   0, 1'b1, 32'h12, 32'h8001,     3'b001, 32'h0,        1'b0, 2);
    txn("lh12",   0, 1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFF8001, 1'b0, 2);
    txn("lhu12",  0, 1'b0, 32'h12, 32'h0,        3'b101, 32'h00008001, 1'b0, 2);
    txn("lw10c",  0, 1'b0, 32'h10, 32'h0,        3'b010, 32'h8001BEEF, 1'b0, 2);
    txn("lh10",   0, 1'b0, 32'h10, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0, 2);
    txn("lb11",   0, 1'b0, 32'h11, 32'h0,        3'b000, 32'hFFFFFFBE, 1'b0, 2);

`ifdef MEM_MISALIGN_CHECK_EN
    txn("lw11",   0, 1'b0, 32'h11, 32'h0,        3'b010, 32'h0,        1'b1, 2);
    txn("lh11",   0, 1'b0, 32'h11, 32'h0,        3'b001, 32'h0,        1'b1, 2);
`else
    txn("lw11",   0, 1'b0, 32'h11, 32'h0,        3'b010, 32'h8001BEEF, 1'b0, 2);
    txn("lh11",   0, 1'b0, 32'h11, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0, 2);
`endif
    txn("f3_011", 0, 1'b0, 32'h10, 32'h0,        3'b011, 32'h0,        1'b1, 2);
    txn("lw_ok",  0, 1'b0, 32'h10, 32'h0,        3'b010, 32'h8001BEEF, 1'b0, 2);

    txn("sw1000", 0, 1'b1, 32'h1000, 32'h12345678, 3'b010, 32'h0,        1'b0, 2);
    txn("lw0",    0, 1'b0, 32'h0,    32'h0,        3'b010, 32'h12345678, 1'b0, 2);
    txn("sbu_st", 0, 1'b1, 32'h0,    32'hFF,       3'b100, 32'h0,        1'b1, 2);
    txn("lw0b",   0, 1'b0, 32'h0,    32'h0,        3'b010, 32'h12345678, 1'b0, 2);

    txn("ws3_sw", 1, 1'b1, 32'h20, 32'hAAAA5555, 3'b010, 32'h0, 1'b0, 4);
    @(negedge clk);
    for (int g = 0; g < 50 && busy_w[1]; g++) @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h20; wdata_v[1] = 32'h11112222; f3_v[1] = 3'b010;
    @(posedge clk);
    acks = 0;
    @(negedge clk);
    req_v[1] = 1'b0;
    @(posedge clk); #1;
    if (ack_w[1]) acks++;
    @(negedge clk);
    rst3 = 1'b1;
    @(posedge clk); #1;
    if (ack_w[1]) acks++;
    check("rst_wait_busy", {31'd0, busy_w[1]}, 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack_w[1]) acks++;
    end
    check("rst_wait_noack", acks, 32'd0);
    txn("ws3_lw", 1, 1'b0, 32'h20, 32'h0, 3'b010, 32'hAAAA5555, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory responder for the multicycle RV32 core: the memory-side end of the CPU's memory interface, answering word fetches, loads and stores. It captures one request at a time, inserts a parameterised number of wait states, performs the byte-lane write or the sign/zero-extended read, and returns the result with a one-cycle acknowledge. It sits outside the CPU and replaces the combinational instruction/data memory so the control FSM can stall on `ack`.

## Interface
- `DEPTH_WORDS`, 1024: memory size in 32-bit words; power of two, ≥ 4.
- `WAIT_STATES`, 1: extra cycles between capture and response; 0..15.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  access request; requester holds it high until `ack`.
- `we`  in  1  1 = store, 0 = load/fetch.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `func3`  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu; fetches use 010.
- `rdata`  out  32  load result, extended per `func3`.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from capture until the `ack` cycle inclusive.
- `err`  out  1  qualified by `ack`; access was rejected.

## Operation
- States IDLE, WAIT, RESP. Reset forces IDLE, `ack`=0, `busy`=0, `err`=0, `rdata`=0, wait counter 0. Memory array is not cleared.
- IDLE: on `req`=1, latch `we`, `addr`, `wdata`, `func3`; load counter with `WAIT_STATES`; go to WAIT if `WAIT_STATES`>0, else RESP. `busy` rises next cycle.
- WAIT: decrement counter each cycle; at 1 go to RESP. Inputs are ignored; dropping `req` does not abort.
- Entering RESP (same edge): execute the latched access, register `rdata`/`err`. In RESP `ack`=1 for one cycle, then back to IDLE. A request held high in that IDLE cycle is captured.
- Word index = `addr[log2(DEPTH_WORDS)+1:2]`; higher address bits are ignored (aliasing wrap).
- Stores: b writes lane `addr[1:0]` from `wdata[7:0]`; h writes lanes {`addr[1]`,0} and {`addr[1]`,1} from `wdata[15:0]`; w writes all four lanes. Other lanes unchanged. `rdata` on store = 0.
- Loads: b/bu select the byte at `addr[1:0]`, h/hu the half at `addr[1]`; b/h sign-extend, bu/hu zero-extend; w returns the full word.
- Reserved `func3` (011, 110, 111, and 100/101 with `we`=1): no write, `rdata`=0, `err`=1.
- Store followed by load to the same word returns the new data.

## Timing
- `req` sampled high at edge N in IDLE → `ack` high during cycle N+1+`WAIT_STATES` → IDLE at N+2+`WAIT_STATES`.
- Throughput: one access per `WAIT_STATES`+2 cycles.
- `rdata`/`err` valid when `ack`=1; held until the next RESP entry or reset.
- Reset in WAIT: pending store discarded, no `ack`. Reset in RESP: `ack` drops next cycle; the store was already committed.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: h/hu with `addr[0]`=1, or w with `addr[1:0]`≠0, is rejected: no write, `rdata`=0, `err`=1.
- Undefined: offending low address bits are forced to zero (h aligns to half, w to word); access completes normally with `err`=0. Reserved-`func3` errors remain in both builds.

## Test plan
- `WAIT_STATES`=1: sw 0xDEADBEEF to 0x10, then lw 0x10 → `ack` exactly 2 cycles after each `req` capture, `rdata`=0xDEADBEEF, `err`=0.
- sb 0x80 to 0x13, then lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080; lw 0x10 → 0x80ADBEEF.
- sh 0x8001 to 0x12 → lh 0x12 = 0xFFFF8001, lhu = 0x00008001, lw 0x10 = 0x8001BEEF.
- lw 0x11 with the macro → `err`=1, `rdata`=0; without the macro → `rdata` equal to lw 0x10, `err`=0; `func3`=011 → `err`=1 in both builds.
- `DEPTH_WORDS`=1024: sw 0x12345678 to 0x1000 → lw 0x0 returns 0x12345678 (wrap).
- `WAIT_STATES`=3: reset asserted 2 cycles after a store capture → no `ack`, `busy`=0 after reset; later lw of that address returns the old value.
